// File: rtl/dbus_pkg.sv
// Shared address map and decode for the CPU data-bus responder.
package dbus_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DISP   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;

  typedef enum logic [2:0] {
    SEL_DRAM,
    SEL_DISP,
    SEL_TMR,
    SEL_LED,
    SEL_SW,
    SEL_NONE
  } sel_t;

  // Anything outside the 4 KiB peripheral page is DRAM; unmapped words in the page decode to NONE.
  function automatic sel_t decode_addr(input logic [31:0] addr);
    sel_t s;
    if (addr[31:12] != PERIPH_BASE[31:12]) begin
      s = SEL_DRAM;
    end else begin
      case (addr)
        ADDR_DISP:  s = SEL_DISP;
        ADDR_TIMER: s = SEL_TMR;
        ADDR_LED:   s = SEL_LED;
        ADDR_SW:    s = SEL_SW;
        default:    s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
module seg7_decode (
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  always_comb begin
    case (hex_i)
      4'h0:    seg_o = 8'hC0;
      4'h1:    seg_o = 8'hF9;
      4'h2:    seg_o = 8'hA4;
      4'h3:    seg_o = 8'hB0;
      4'h4:    seg_o = 8'h99;
      4'h5:    seg_o = 8'h92;
      4'h6:    seg_o = 8'h82;
      4'h7:    seg_o = 8'hF8;
      4'h8:    seg_o = 8'h80;
      4'h9:    seg_o = 8'h90;
      4'hA:    seg_o = 8'h88;
      4'hB:    seg_o = 8'h83;
      4'hC:    seg_o = 8'hC6;
      4'hD:    seg_o = 8'hA1;
      4'hE:    seg_o = 8'h86;
      default: seg_o = 8'h8E;
    endcase
  end

endmodule

// File: rtl/dbus_bridge.sv
// CPU data-port responder: decodes loads/stores into DRAM or the LED, switch,
// timer and 7-segment display registers. Read data is combinational.
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int DRAM_AW   = 14,
  parameter int SCAN_DIV  = 50000,
  parameter int TMR_PRESC = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        cpu_addr,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw_in,
  output logic [23:0]        led_out,
  output logic [7:0]         dn_en,
  output logic [7:0]         dn_seg
);

  localparam int PW = (TMR_PRESC > 1) ? $clog2(TMR_PRESC) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TMR_PRESC - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);

  sel_t sel;
  logic wr_disp, wr_tmr, wr_led;

  logic [23:0]   sw_meta_q, sw_sync_q;
  logic [23:0]   led_q, led_d;
  logic [31:0]   timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   disp_q, disp_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    dn_en_q, dn_seg_q;
  logic [3:0]    nib_nxt;
  logic [7:0]    seg_nxt;

  assign sel     = decode_addr(cpu_addr);
  assign wr_disp = cpu_we && (sel == SEL_DISP);
  assign wr_tmr  = cpu_we && (sel == SEL_TMR);
  assign wr_led  = cpu_we && (sel == SEL_LED);

  assign dram_addr  = cpu_addr[DRAM_AW+1:2];
  assign dram_we    = cpu_we && (sel == SEL_DRAM);
  assign dram_wdata = cpu_wdata;

  always_comb begin
    case (sel)
      SEL_DRAM: cpu_rdata = dram_rdata;
      SEL_DISP: cpu_rdata = disp_q;
      SEL_TMR:  cpu_rdata = timer_q;
      SEL_LED:  cpu_rdata = {8'h00, led_q};
      SEL_SW:   cpu_rdata = {8'h00, sw_sync_q};
      default:  cpu_rdata = 32'h0;
    endcase
  end

  // A timer store also restarts the prescaler, so a tick on the same edge is dropped.
  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    if (wr_tmr) begin
      timer_d = cpu_wdata;
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      timer_d = timer_q + 32'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    led_d  = wr_led ? cpu_wdata[23:0] : led_q;
    disp_d = wr_disp ? cpu_wdata : disp_q;
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end
  end

  // Decode from next-state values so the registered digit outputs track a store immediately.
  assign nib_nxt = disp_d[{idx_d, 2'b00} +: 4];

  seg7_decode u_seg7 (
    .hex_i (nib_nxt),
    .seg_o (seg_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      presc_q   <= '0;
      disp_q    <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      dn_en_q   <= 8'hFE;
      dn_seg_q  <= 8'hC0;
    end else begin
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      disp_q    <= disp_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dn_en_q   <= ~(8'b1 << idx_d);
      dn_seg_q  <= seg_nxt;
    end
  end

  assign led_out = led_q;
  assign dn_en   = dn_en_q;
  assign dn_seg  = dn_seg_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed and randomized bench for dbus_bridge against a cycle-count reference model.
module tb_dbus_bridge;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_we;
  logic [AW-1:0] dram_addr;
  logic          dram_we;
  logic [31:0]   dram_wdata, dram_rdata;
  logic [23:0]   sw_in, led_out;
  logic [7:0]    dn_en, dn_seg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dbus_bridge #(.DRAM_AW(AW), .SCAN_DIV(4), .TMR_PRESC(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .dn_en      (dn_en),
    .dn_seg     (dn_seg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external DRAM: asynchronous read, synchronous write
  logic [31:0] dram_mem [0:(1<<AW)-1];
  assign dram_rdata = dram_mem[dram_addr];
  always @(posedge clk) if (dram_we) dram_mem[dram_addr] <= dram_wdata;

  // reference model state
  logic [31:0] ref_mem [int];
  logic [23:0] led_m;
  logic [31:0] disp_m;
  logic [31:0] tmr_base;
  int          tmr_l;
  int          scan_l;
  logic [23:0] sw_old, sw_new;
  int          sw_chg;
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [23:0] sw_exp();
    return ((cyc - sw_chg) >= 2) ? sw_new : sw_old;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:12] != 20'hFFFFF) return ref_mem.exists(int'(a[9:2])) ? ref_mem[int'(a[9:2])] : 32'h0;
    case (a)
      32'hFFFF_F000: return disp_m;
      32'hFFFF_F020: return tmr_base + 32'((cyc - tmr_l) / 3);
      32'hFFFF_F060: return {8'h00, led_m};
      32'hFFFF_F070: return {8'h00, sw_exp()};
      default:       return 32'h0;
    endcase
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_outputs(input string tag);
    int k, idx;
    logic [3:0] nib;
    k   = cyc - scan_l;
    idx = (k / 4) % 8;
    nib = 4'((disp_m >> (4 * idx)) & 32'hF);
    chk({tag, ".led"}, {8'h0, led_out}, {8'h0, led_m});
    chk({tag, ".dn_en"}, {24'h0, dn_en}, {24'h0, ~(8'b1 << idx)});
    chk({tag, ".dn_seg"}, {24'h0, dn_seg}, {24'h0, seg_tab[nib]});
  endtask

  // driver tasks: drive 1 ns after the edge, check before the next one
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input string tag);
    logic is_dram;
    is_dram   = (a[31:12] != 20'hFFFFF);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    #1;
    chk({tag, ".dram_we"}, {31'h0, dram_we}, {31'h0, is_dram});
    if (is_dram) begin
      chk({tag, ".dram_addr"}, {24'h0, dram_addr}, {24'h0, a[9:2]});
      chk({tag, ".dram_wdata"}, dram_wdata, d);
    end
    step();
    cpu_we = 1'b0;
    if (is_dram) ref_mem[int'(a[9:2])] = d;
    else if (a == 32'hFFFF_F060) led_m = d[23:0];
    else if (a == 32'hFFFF_F000) disp_m = d;
    else if (a == 32'hFFFF_F020) begin
      tmr_base = d;
      tmr_l    = cyc;
    end
  endtask

  task automatic load(input logic [31:0] a, input string tag);
    cpu_addr = a;
    cpu_we   = 1'b0;
    #1;
    chk({tag, ".rdata"}, cpu_rdata, model_read(a));
    chk({tag, ".dram_we"}, {31'h0, dram_we}, 32'h0);
    step();
  endtask

  task automatic set_sw(input logic [23:0] v);
    sw_old = sw_exp();
    sw_new = v;
    sw_in  = v;
    sw_chg = cyc;
  endtask

  function automatic logic [31:0] rnd_dram_addr();
    logic [3:0] w;
    w = 4'($urandom_range(0, 15));
    return {2'b00, 20'($urandom), 4'b0000, w, 2'($urandom)};
  endfunction

  task automatic model_reset();
    led_m    = '0;
    disp_m   = '0;
    tmr_base = '0;
    tmr_l    = cyc;
    scan_l   = cyc;
    sw_old   = '0;
    sw_new   = sw_in;
    sw_chg   = cyc;
  endtask

  initial begin
    logic [31:0] a, d;
    int op;
    for (int i = 0; i < (1 << AW); i++) dram_mem[i] = 32'h0;
    rst_n = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.led", {8'h0, led_out}, 32'h0);
    chk("reset.dn_en", {24'h0, dn_en}, 32'hFE);
    chk("reset.dn_seg", {24'h0, dn_seg}, 32'hC0);
    rst_n = 1'b1;
    model_reset();
    chk_outputs("post_reset");

    // 1: DRAM store then load
    store(32'h0000_0010, 32'hDEAD_BEEF, "t1.store");
    load(32'h0000_0010, "t1.load");
    chk_outputs("t1");

    // 2: LED register
    store(32'hFFFF_F060, 32'h00A5_5A5A, "t2.store");
    chk_outputs("t2");
    load(32'hFFFF_F060, "t2.load");

    // 3: switch synchroniser latency
    set_sw(24'h123456);
    for (int i = 0; i < 4; i++) load(32'hFFFF_F070, "t3.sw");

    // 4: display scan through all digits
    store(32'hFFFF_F000, 32'h8765_4321, "t4.store");
    for (int i = 0; i < 36; i++) begin
      chk_outputs("t4");
      step();
    end
    load(32'hFFFF_F000, "t4.load");

    // 5: timer wrap and store on a tick edge
    store(32'hFFFF_F020, 32'hFFFF_FFFE, "t5.store");
    for (int i = 0; i < 8; i++) load(32'hFFFF_F020, "t5.tmr");
    while (((cyc - tmr_l) % 3) != 2) step();
    store(32'hFFFF_F020, 32'h1234_5678, "t5.tick_store");
    load(32'hFFFF_F020, "t5.tick_load");

    // randomized mix
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: store(rnd_dram_addr(), $urandom, "r.dram_st");
        1: load(rnd_dram_addr(), "r.dram_ld");
        2: store(32'hFFFF_F060, $urandom, "r.led_st");
        3: load(32'hFFFF_F060, "r.led_ld");
        4: load(32'hFFFF_F020, "r.tmr_ld");
        5: store(32'hFFFF_F000, $urandom, "r.disp_st");
        6: load(32'hFFFF_F000, "r.disp_ld");
        7: begin
          if ((cyc - sw_chg) >= 2) set_sw(24'($urandom));
          load(32'hFFFF_F070, "r.sw_ld");
        end
        8: begin
          a = 32'hFFFF_F000 + 32'(4 * $urandom_range(0, 1023));
          if (a == 32'hFFFF_F000 || a == 32'hFFFF_F020 || a == 32'hFFFF_F060 || a == 32'hFFFF_F070)
            a = 32'hFFFF_F004;
          store(a, $urandom, "r.none_st");
          load(a, "r.none_ld");
        end
        default: store(32'hFFFF_F020, $urandom, "r.tmr_st");
      endcase
      chk_outputs("r");
    end

    // 6: asynchronous reset mid-scan with a coincident store
    store(32'hFFFF_F060, 32'h00FF_FFFF, "t6.led");
    store(32'hFFFF_F000, 32'hFEDC_BA98, "t6.disp");
    step();
    d = 32'h0012_3456;
    cpu_addr = 32'hFFFF_F060; cpu_wdata = d; cpu_we = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6.led_out", {8'h0, led_out}, 32'h0);
    chk("t6.dn_en", {24'h0, dn_en}, 32'hFE);
    chk("t6.dn_seg", {24'h0, dn_seg}, 32'hC0);
    step();
    cpu_we = 1'b0; cpu_addr = 32'hFFFF_F020;
    #1;
    chk("t6.timer", cpu_rdata, 32'h0);
    cpu_addr = 32'h0000_0010;
    #1;
    chk("t6.dram_passthru", cpu_rdata, model_read(32'h0000_0010));
    rst_n = 1'b1;
    model_reset();
    chk_outputs("t6.post");
    load(32'hFFFF_F060, "t6.led_ld");
    load(32'hFFFF_F020, "t6.tmr_ld");
    for (int i = 0; i < 6; i++) load(32'hFFFF_F070, "t6.sw_ld");
    chk_outputs("t6.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
